// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the machine-mode trap sequencer and the CSR file.
// Contents: the sequencer state encoding, privilege level codes, mstatus
// field positions, the mtvec vectored-mode code and the mstatus update
// functions for trap entry and MRET. The functions work on mstatus[12:0],
// which holds every field they touch.
package trap_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_CSR      = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_t;

    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] PRIV_U = 2'b00;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MPP_LO   = 11;

    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- privilege at the trap.
    function automatic logic [12:0] mstatus_trap_lo(input logic [12:0] st,
                                                    input logic [1:0]  prv);
        logic [12:0] r;
        r                 = st;
        r[MPIE_BIT]       = st[MIE_BIT];
        r[MIE_BIT]        = 1'b0;
        r[MPP_LO+1:MPP_LO] = prv;
        return r;
    endfunction

    // MRET: MIE <- MPIE, MPIE <- 1, MPP <- U.
    function automatic logic [12:0] mstatus_mret_lo(input logic [12:0] st);
        logic [12:0] r;
        r                 = st;
        r[MIE_BIT]        = st[MPIE_BIT];
        r[MPIE_BIT]       = 1'b1;
        r[MPP_LO+1:MPP_LO] = PRIV_U;
        return r;
    endfunction

endpackage

// File: rtl/trap_sequencer_checker.sv
// Simulation-only protocol checker for trap_sequencer.
// Flags any trap or MRET request raised while the sequencer is busy; such
// requests are dropped by the sequencer, so commit must never issue them.
// Ports: clk, reset, busy, trap_req, mret_req (all inputs).
module trap_sequencer_checker (
    input logic clk,
    input logic reset,
    input logic busy,
    input logic trap_req,
    input logic mret_req
);

    // Sample the request lines every cycle the sequencer is occupied.
    always @(posedge clk) begin
        if (!reset && busy) begin
            assert (!(trap_req || mret_req))
                else $error("trap_sequencer: request raised while busy is dropped");
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET return sequencer.
// On a committing exception/ECALL/EBREAK (trap_req) or legal MRET (mret_req)
// sampled in IDLE it latches the context, then runs:
//   FLUSH (flush=1 for FLUSH_CYCLES cycles) -> CSR (one-cycle csr_we strobe)
//   -> REDIRECT (redirect_valid held until redirect_ready).
// busy is high whenever not IDLE so commit stalls.
// Inputs : clk, reset (sync, active high), trap_req, mret_req, trap_pc,
//          trap_cause, mtvec, mepc, mstatus, redirect_ready.
// Outputs: busy, flush, csr_we, csr_we_trap, mepc_wdata, mcause_wdata,
//          mstatus_wdata, priv, redirect_valid, redirect_pc.
// Build option: define TRAP_VECTORED_EN to honour mtvec vectored mode for
// interrupts; without it every trap jumps to the mtvec base.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            trap_req,
    input  logic            mret_req,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [7:0]      trap_cause,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] mstatus,
    input  logic            redirect_ready,
    output logic            busy,
    output logic            flush,
    output logic            csr_we,
    output logic [XLEN-1:0] mepc_wdata,
    output logic [7:0]      mcause_wdata,
    output logic [XLEN-1:0] mstatus_wdata,
    output logic            csr_we_trap,
    output logic [1:0]      priv,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    trap_state_t       state_r;
    trap_state_t       next_state_s;
    logic [CNT_W-1:0]  flush_cnt_r;
    logic              is_trap_r;
    logic [XLEN-1:0]   pc_lat_r;
    logic [7:0]        cause_lat_r;
    logic [1:0]        priv_lat_r;
    logic [1:0]        priv_r;
    logic [XLEN-1:0]   trap_target_s;
    logic              req_s;
    logic              unused_s;

    assign req_s = trap_req || mret_req;
    assign priv  = priv_r;
    assign unused_s = ^{pc_lat_r[1:0], mepc[1:0], mtvec[1:0]};

    // Trap target: mtvec base, or base + 4*cause for vectored interrupts.
`ifdef TRAP_VECTORED_EN
    always_comb begin
        if ((mtvec[1:0] == MTVEC_VECTORED) && cause_lat_r[7]) begin
            trap_target_s = {mtvec[XLEN-1:2], 2'b00}
                          + {{(XLEN-9){1'b0}}, cause_lat_r[6:0], 2'b00};
        end else begin
            trap_target_s = {mtvec[XLEN-1:2], 2'b00};
        end
    end
`else
    always_comb begin
        trap_target_s = {mtvec[XLEN-1:2], 2'b00};
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:     next_state_s = req_s ? ST_FLUSH : ST_IDLE;
            ST_FLUSH:    next_state_s = (flush_cnt_r == {CNT_W{1'b0}}) ? ST_CSR : ST_FLUSH;
            ST_CSR:      next_state_s = ST_REDIRECT;
            ST_REDIRECT: next_state_s = redirect_ready ? ST_IDLE : ST_REDIRECT;
            default:     next_state_s = ST_IDLE;
        endcase
    end

    // Strobe outputs, decoded from state only.
    always_comb begin
        busy           = (state_r != ST_IDLE);
        flush          = (state_r == ST_FLUSH);
        csr_we         = (state_r == ST_CSR);
        csr_we_trap    = (state_r == ST_CSR) && is_trap_r;
        redirect_valid = (state_r == ST_REDIRECT);
    end

    // Context latch, flush counter, CSR write data, privilege and redirect target.
    // CSR data is registered on the last flush cycle so it is stable under csr_we;
    // the redirect target is registered on the CSR cycle and held in REDIRECT.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt_r   <= {CNT_W{1'b0}};
            is_trap_r     <= 1'b0;
            pc_lat_r      <= {XLEN{1'b0}};
            cause_lat_r   <= 8'h00;
            priv_lat_r    <= PRIV_M;
            priv_r        <= PRIV_M;
            mepc_wdata    <= {XLEN{1'b0}};
            mcause_wdata  <= 8'h00;
            mstatus_wdata <= {XLEN{1'b0}};
            redirect_pc   <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        is_trap_r   <= trap_req;
                        pc_lat_r    <= trap_pc;
                        cause_lat_r <= trap_cause;
                        priv_lat_r  <= priv_r;
                        flush_cnt_r <= CNT_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_r != {CNT_W{1'b0}}) begin
                        flush_cnt_r <= flush_cnt_r - CNT_W'(1);
                    end else if (is_trap_r) begin
                        mepc_wdata    <= {pc_lat_r[XLEN-1:2], 2'b00};
                        mcause_wdata  <= cause_lat_r;
                        mstatus_wdata <= {mstatus[XLEN-1:13],
                                          mstatus_trap_lo(mstatus[12:0], priv_lat_r)};
                    end else begin
                        mepc_wdata    <= {XLEN{1'b0}};
                        mcause_wdata  <= 8'h00;
                        mstatus_wdata <= {mstatus[XLEN-1:13],
                                          mstatus_mret_lo(mstatus[12:0])};
                    end
                end
                ST_CSR: begin
                    if (is_trap_r) begin
                        priv_r      <= PRIV_M;
                        redirect_pc <= trap_target_s;
                    end else begin
                        priv_r      <= mstatus[MPP_LO+1:MPP_LO];
                        redirect_pc <= {mepc[XLEN-1:2], 2'b00};
                    end
                end
                ST_REDIRECT: begin
                    flush_cnt_r <= flush_cnt_r;
                end
                default: begin
                    flush_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    trap_sequencer_checker u_checker (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .trap_req (trap_req),
        .mret_req (mret_req)
    );

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer. A second instance with
// FLUSH_CYCLES=1 shares the stimulus to cover the single-flush-cycle case.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        reset, trap_req, mret_req, redirect_ready;
    logic [31:0] trap_pc, mtvec, mepc, mstatus;
    logic [7:0]  trap_cause;

    logic        busy, flush, csr_we, csr_we_trap, redirect_valid;
    logic [31:0] mepc_wdata, mstatus_wdata, redirect_pc;
    logic [7:0]  mcause_wdata;
    logic [1:0]  priv;

    logic        busy1, flush1, csr_we1, csr_we_trap1, redirect_valid1;
    logic [31:0] mepc_wdata1, mstatus_wdata1, redirect_pc1;
    logic [7:0]  mcause_wdata1;
    logic [1:0]  priv1;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_vec;

    always #5 clk = ~clk;

    trap_sequencer #(.FLUSH_CYCLES(2), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .trap_req(trap_req), .mret_req(mret_req),
        .trap_pc(trap_pc), .trap_cause(trap_cause), .mtvec(mtvec), .mepc(mepc),
        .mstatus(mstatus), .redirect_ready(redirect_ready), .busy(busy),
        .flush(flush), .csr_we(csr_we), .mepc_wdata(mepc_wdata),
        .mcause_wdata(mcause_wdata), .mstatus_wdata(mstatus_wdata),
        .csr_we_trap(csr_we_trap), .priv(priv), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    trap_sequencer #(.FLUSH_CYCLES(1), .XLEN(32)) dut1 (
        .clk(clk), .reset(reset), .trap_req(trap_req), .mret_req(mret_req),
        .trap_pc(trap_pc), .trap_cause(trap_cause), .mtvec(mtvec), .mepc(mepc),
        .mstatus(mstatus), .redirect_ready(redirect_ready), .busy(busy1),
        .flush(flush1), .csr_we(csr_we1), .mepc_wdata(mepc_wdata1),
        .mcause_wdata(mcause_wdata1), .mstatus_wdata(mstatus_wdata1),
        .csr_we_trap(csr_we_trap1), .priv(priv1), .redirect_valid(redirect_valid1),
        .redirect_pc(redirect_pc1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    initial begin
        reset = 1'b1; trap_req = 1'b0; mret_req = 1'b0; redirect_ready = 1'b0;
        trap_pc = 32'h0; trap_cause = 8'h00; mtvec = 32'h0; mepc = 32'h0; mstatus = 32'h0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_csr_we", {31'd0, csr_we}, 32'd0);
        check("rst_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst_priv", {30'd0, priv}, 32'd3);
        check("rst_rpc", redirect_pc, 32'h0);
        check("rst_mstatus_wd", mstatus_wdata, 32'h0);

        // 1. Trap entry
        trap_pc = 32'h100; trap_cause = 8'h0B; mtvec = 32'h200; mstatus = 32'h8;
        redirect_ready = 1'b1; trap_req = 1'b1;
        tick(); trap_req = 1'b0;
        check("t1_flush_c1", {31'd0, flush}, 32'd1);
        check("t1_busy_c1", {31'd0, busy}, 32'd1);
        check("t1_f1_flush", {31'd0, flush1}, 32'd1);
        tick();
        check("t1_flush_c2", {31'd0, flush}, 32'd1);
        check("t1_f1_csr_we", {31'd0, csr_we1}, 32'd1);
        tick();
        check("t1_flush_off", {31'd0, flush}, 32'd0);
        check("t1_csr_we", {31'd0, csr_we}, 32'd1);
        check("t1_csr_we_trap", {31'd0, csr_we_trap}, 32'd1);
        check("t1_mepc_wd", mepc_wdata, 32'h100);
        check("t1_mcause_wd", {24'd0, mcause_wdata}, 32'h0B);
        check("t1_mstatus_wd", mstatus_wdata, 32'h1880);
        check("t1_f1_valid", {31'd0, redirect_valid1}, 32'd1);
        tick();
        check("t1_csr_we_off", {31'd0, csr_we}, 32'd0);
        check("t1_valid", {31'd0, redirect_valid}, 32'd1);
        check("t1_rpc", redirect_pc, 32'h200);
        check("t1_priv", {30'd0, priv}, 32'd3);
        check("t1_busy_c4", {31'd0, busy}, 32'd1);
        check("t1_f1_idle", {31'd0, busy1}, 32'd0);
        tick();
        check("t1_idle", {31'd0, busy}, 32'd0);
        check("t1_valid_off", {31'd0, redirect_valid}, 32'd0);

        // 2. MRET return
        mepc = 32'h104; mstatus = 32'h80; mret_req = 1'b1;
        tick(); mret_req = 1'b0;
        tick(); tick();
        check("t2_csr_we", {31'd0, csr_we}, 32'd1);
        check("t2_csr_we_trap", {31'd0, csr_we_trap}, 32'd0);
        check("t2_mstatus_wd", mstatus_wdata, 32'h88);
        check("t2_mepc_wd", mepc_wdata, 32'h0);
        check("t2_mcause_wd", {24'd0, mcause_wdata}, 32'h0);
        tick();
        check("t2_priv", {30'd0, priv}, 32'd0);
        check("t2_rpc", redirect_pc, 32'h104);
        tick();
        check("t2_idle", {31'd0, busy}, 32'd0);

        // 3. Backpressure; trap from U mode latches MPP=00 and aligns mepc
        trap_pc = 32'h2A2; trap_cause = 8'h02; mtvec = 32'h300; mstatus = 32'h0;
        redirect_ready = 1'b0; trap_req = 1'b1;
        tick(); trap_req = 1'b0;
        tick(); tick();
        check("t3_mepc_wd", mepc_wdata, 32'h2A0);
        check("t3_mstatus_wd", mstatus_wdata, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", {31'd0, redirect_valid}, 32'd1);
            check("t3_hold_rpc", redirect_pc, 32'h300);
            check("t3_hold_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        check("t3_still_valid", {31'd0, redirect_valid}, 32'd1);
        check("t3_priv_m", {30'd0, priv}, 32'd3);
        redirect_ready = 1'b1;
        tick();
        check("t3_idle", {31'd0, busy}, 32'd0);
        check("t3_valid_off", {31'd0, redirect_valid}, 32'd0);

        // 4. Simultaneous requests: trap wins
        trap_pc = 32'h400; trap_cause = 8'h03; mtvec = 32'h500; mepc = 32'h104;
        mstatus = 32'h8; trap_req = 1'b1; mret_req = 1'b1;
        tick(); trap_req = 1'b0; mret_req = 1'b0;
        tick(); tick();
        check("t4_csr_we_trap", {31'd0, csr_we_trap}, 32'd1);
        check("t4_mcause_wd", {24'd0, mcause_wdata}, 32'h03);
        tick();
        check("t4_rpc", redirect_pc, 32'h500);
        tick();
        check("t4_idle", {31'd0, busy}, 32'd0);

        // Drop to U mode, then 5. reset during the second flush cycle
        mepc = 32'h600; mstatus = 32'h80; mret_req = 1'b1;
        tick(); mret_req = 1'b0;
        tick(); tick(); tick(); tick();
        check("t5_pre_priv_u", {30'd0, priv}, 32'd0);
        trap_pc = 32'h700; trap_cause = 8'h04; mtvec = 32'h800; trap_req = 1'b1;
        tick(); trap_req = 1'b0;
        tick();
        check("t5_in_flush2", {31'd0, flush}, 32'd1);
        reset = 1'b1;
        tick();
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_flush", {31'd0, flush}, 32'd0);
        check("t5_csr_we", {31'd0, csr_we}, 32'd0);
        check("t5_valid", {31'd0, redirect_valid}, 32'd0);
        check("t5_priv", {30'd0, priv}, 32'd3);
        check("t5_mepc_wd", mepc_wdata, 32'h0);
        check("t5_mstatus_wd", mstatus_wdata, 32'h0);
        check("t5_rpc", redirect_pc, 32'h0);
        reset = 1'b0;
        tick();
        check("t5_csr_we_after", {31'd0, csr_we}, 32'd0);

        // 6. Vectored mtvec: interrupt, then exception
`ifdef TRAP_VECTORED_EN
        exp_vec = 32'h21C;
`else
        exp_vec = 32'h200;
`endif
        trap_pc = 32'h10; trap_cause = 8'h87; mtvec = 32'h201; mstatus = 32'h0;
        redirect_ready = 1'b1; trap_req = 1'b1;
        tick(); trap_req = 1'b0;
        tick(); tick();
        check("t6_mcause_wd", {24'd0, mcause_wdata}, 32'h87);
        tick();
        check("t6_rpc_irq", redirect_pc, exp_vec);
        tick();
        trap_cause = 8'h05; trap_req = 1'b1;
        tick(); trap_req = 1'b0;
        tick(); tick(); tick();
        check("t6_rpc_exc", redirect_pc, 32'h200);
        tick();
        check("t6_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
Controller that sequences machine-mode trap entry and MRET return after the commit stage flags a committing exception, ECALL/EBREAK or legal MRET.
Latches the trap context, then runs a fixed sequence:
- pipeline flush (ROB, reservation stations, JALR queue, RAS pointer);
- CSR updates (mepc, mcause, mstatus, privilege);
- fetch redirect over a valid/ready handshake.
Stalls commit while busy. Sits between the commit unit, the CSR file and the fetch/PC unit.

Parameters:
FLUSH_CYCLES, 2, cycles `flush` is held high (≥1)
XLEN, 32, data/PC width

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
trap_req  input  1  commit is retiring an exception/ECALL/EBREAK this cycle
mret_req  input  1  commit is retiring a legal MRET this cycle
trap_pc  input  XLEN  PC of the faulting/committing instruction
trap_cause  input  8  mcause value, bit 7 = interrupt flag
mtvec  input  XLEN  current mtvec CSR
mepc  input  XLEN  current mepc CSR (MRET target)
mstatus  input  XLEN  current mstatus CSR
redirect_ready  input  1  fetch accepts redirect
busy  output  1  sequencer not IDLE; commit must not retire
flush  output  1  flush all speculative state
csr_we  output  1  one-cycle strobe: write mepc/mcause/mstatus outputs
mepc_wdata  output  XLEN  new mepc
mcause_wdata  output  8  new mcause
mstatus_wdata  output  XLEN  new mstatus
csr_we_trap  output  1  qualifies csr_we: 1 = trap entry (all three CSRs), 0 = MRET (mstatus only)
priv  output  2  current privilege, 2'b11 = M, 2'b00 = U
redirect_valid  output  1  redirect target valid
redirect_pc  output  XLEN  redirect target

Behaviour:
- Reset: state IDLE; priv = 2'b11.
- Outputs after reset: busy, flush, csr_we, csr_we_trap and redirect_valid are 0; all data outputs are 0.
- States: IDLE, FLUSH, CSR, REDIRECT.
- IDLE, request present:
  - Any request is sampled in IDLE and moves to FLUSH next cycle.
  - trap_req has priority over mret_req if both are high; the MRET is dropped.
  - Latch kind, trap_pc, trap_cause and priv into internal registers.
  - Load the flush counter with FLUSH_CYCLES-1.
- FLUSH: flush=1 and busy=1. Decrement the counter; go to CSR when the counter is 0. Exactly FLUSH_CYCLES cycles.
- CSR: csr_we=1 for exactly one cycle, then REDIRECT.
  - Trap entry:
    - mepc_wdata = {latched pc[XLEN-1:2], 2'b00}; mcause_wdata = latched cause.
    - mstatus_wdata = mstatus with MPIE(7) ← MIE(3), MIE ← 0, MPP(12:11) ← latched priv.
    - priv ← 2'b11.
  - MRET:
    - mstatus_wdata = mstatus with MIE ← MPIE, MPIE ← 1, MPP ← 2'b00.
    - priv ← mstatus.MPP.
    - mepc_wdata and mcause_wdata are 0.
- REDIRECT: redirect_valid=1.
  - redirect_pc = {mtvec[XLEN-1:2], 2'b00} for a trap; mepc & ~3 for MRET.
  - Hold valid and pc stable until redirect_ready, then IDLE next cycle.
  - Transfer occurs on valid & ready.
- busy = (state != IDLE). Combinational from state only; no input→output path.
- Requests arriving while busy: ignored, and flagged by a simulation assertion.
- Minimum trap latency, request to redirect accepted: 1 + FLUSH_CYCLES + 1 + 1 cycles.
- Reset mid-sequence:
  - Returns to IDLE in the next cycle and all strobes drop.
  - Any partial CSR write already issued stands.
  - priv returns to M.
- FLUSH_CYCLES = 1 is legal: a single flush cycle.

Optional Feature:
TRAP_VECTORED_EN.
- Defined: when mtvec[1:0]==2'b01 and latched cause bit 7 = 1, trap redirect_pc = {mtvec[XLEN-1:2],2'b00} + (cause[6:0] << 2).
- Defined: exceptions (bit 7 = 0) still use the base address.
- Undefined: always direct mode; mtvec[1:0] ignored.

Decomposition:
- Shared package gets:
  - the state enum trap_state_t;
  - PRIV_M/PRIV_U constants;
  - mstatus bit positions (MIE_BIT=3, MPIE_BIT=7, MPP_LO=11);
  - the mtvec mode constant MTVEC_VECTORED=2'b01.
- No sub-module required. The mstatus update function may live in the package as a function shared with the CSR file.

Test Plan:
1. Trap entry:
   - Stimulus: reset; trap_req with trap_pc=0x100, cause=0x0B, mtvec=0x200, mstatus.MIE=1, redirect_ready=1.
   - Response: flush high 2 cycles; csr_we with mepc=0x100, mcause=0x0B, MPIE=1, MIE=0, MPP=11; redirect_pc=0x200; busy for 4 cycles.
2. MRET return:
   - Stimulus: mret_req with mepc=0x104, mstatus.MPIE=1, MPP=00.
   - Response: mstatus_wdata MIE=1, MPIE=1, MPP=00; priv→00; redirect_pc=0x104; csr_we_trap=0.
3. Backpressure:
   - Stimulus: redirect_ready held low 5 cycles in REDIRECT.
   - Response: redirect_valid and redirect_pc stable; busy=1 throughout; IDLE the cycle after ready rises.
4. Simultaneous requests:
   - Stimulus: trap_req and mret_req in the same cycle.
   - Response: trap sequence only; redirect_pc = mtvec base.
5. Reset in FLUSH:
   - Stimulus: reset asserted during the second flush cycle.
   - Response: next cycle all outputs 0, priv=11, no csr_we seen.
6. Vectored mode (TRAP_VECTORED_EN):
   - Stimulus: mtvec=0x201, cause=0x87.
   - Response: redirect_pc=0x21C. With the macro off: 0x200.
